// File: rtl/zint_mc_if.sv
// Bus bundle between the Z80-side host logic and the zint_mc interrupt controller.
// The master side drives strobes, requests and CPU cycle signals; the slave side is the controller.
interface zint_mc_if #(
  parameter int CHANNELS = 4,
  parameter int CTR_W    = 10
);
  logic                zpos;
  logic                zneg;
  logic [CHANNELS-1:0] int_req;
  logic [CHANNELS-1:0] int_en;
  logic [CTR_W-1:0]    pulse_len;
  logic [7:0]          vec_base;
  logic                iorq_n;
  logic                m1_n;
  logic                int_n;
  logic [7:0]          int_vec;
  logic                int_vec_oe;
  logic [CHANNELS-1:0] int_ack;
  logic [CHANNELS-1:0] int_miss;

  modport master (
    output zpos, zneg, int_req, int_en, pulse_len, vec_base, iorq_n, m1_n,
    input  int_n, int_vec, int_vec_oe, int_ack, int_miss
  );

  modport slave (
    input  zpos, zneg, int_req, int_en, pulse_len, vec_base, iorq_n, m1_n,
    output int_n, int_vec, int_vec_oe, int_ack, int_miss
  );
endinterface

// File: rtl/zint_mc.sv
// Multi-channel Z80 IM2 interrupt controller: per-channel pending latches, fixed priority,
// timed INT pulse with acknowledge/vector phase and timeout (miss) reporting.
module zint_mc #(
  parameter int CHANNELS = 4,
  parameter int CTR_W    = 10
) (
  input logic       fclk,
  input logic       rst,
  zint_mc_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, ACKWAIT} state_t;

  state_t              r_state;
  logic [CHANNELS-1:0] r_pend;
  logic [2:0]          r_chan;
  logic [CTR_W-1:0]    r_ctr;
  logic                r_int_n;
  logic [7:0]          r_vec;
  logic                r_vec_oe;
  logic [CHANNELS-1:0] r_ack;
  logic [CHANNELS-1:0] r_miss;

  logic [2:0]          w_first;
  logic [CHANNELS-1:0] w_chan_oh;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clr;
  logic [CTR_W-1:0]    w_limit;
  logic                w_ack_cond;
  logic                w_chan_en;
  logic                w_timeout;
  logic                w_unused_zpos;

  // zpos is part of the bus for pin compatibility only.
  assign w_unused_zpos = bus.zpos;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_first   = '0;
    w_chan_oh = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (r_pend[i]) w_first = 3'(i);
    end
    for (int i = 0; i < CHANNELS; i++) begin
      w_chan_oh[i] = (r_chan == 3'(i));
    end
  end

  assign w_set      = bus.int_req & bus.int_en;
  assign w_ack_cond = !bus.iorq_n && !bus.m1_n && bus.zneg;
  assign w_chan_en  = |(bus.int_en & w_chan_oh);
  // A zero pulse length is treated as one cycle.
  assign w_limit    = (bus.pulse_len == '0) ? '0 : bus.pulse_len - CTR_W'(1);
  assign w_timeout  = (r_ctr == w_limit);

  always_comb begin
    w_clr = '0;
    if (r_state == ASSERT && w_chan_en && (w_ack_cond || w_timeout)) w_clr = w_chan_oh;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pend   <= '0;
      r_chan   <= '0;
      r_ctr    <= '0;
      r_int_n  <= 1'b1;
      r_vec    <= '0;
      r_vec_oe <= 1'b0;
      r_ack    <= '0;
      r_miss   <= '0;
    end else begin
      r_ack  <= '0;
      r_miss <= '0;
      // Set beats clear; a disabled channel drops its request regardless.
      r_pend <= ((r_pend & ~w_clr) | w_set) & bus.int_en;
      case (r_state)
        IDLE: begin
          if (|r_pend) begin
            r_chan  <= w_first;
            r_ctr   <= '0;
            r_int_n <= 1'b0;
            r_state <= ASSERT;
          end
        end
        ASSERT: begin
          if (!w_chan_en) begin
            r_int_n <= 1'b1;
            r_state <= IDLE;
          end else if (w_ack_cond) begin
            r_int_n  <= 1'b1;
            r_vec    <= {bus.vec_base[7:4], r_chan, bus.vec_base[0]};
            r_vec_oe <= 1'b1;
            r_ack    <= w_chan_oh;
            r_state  <= ACKWAIT;
          end else if (w_timeout) begin
            r_int_n <= 1'b1;
            r_miss  <= w_chan_oh;
            r_state <= IDLE;
          end else if (r_ctr != '1) begin
            r_ctr <= r_ctr + CTR_W'(1);
          end
        end
        ACKWAIT: begin
          if (bus.iorq_n && bus.m1_n) begin
            r_vec_oe <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.int_n      = r_int_n;
  assign bus.int_vec    = r_vec;
  assign bus.int_vec_oe = r_vec_oe;
  assign bus.int_ack    = r_ack;
  assign bus.int_miss   = r_miss;

endmodule

// File: tb/tb_zint_mc.sv
// Self-checking bench for zint_mc: directed scenarios plus a randomized pass checked
// against a pulse-level model (priority order, vector formula, pulse length).
module tb_zint_mc;
  localparam int CH = 4;
  localparam int CW = 10;

  logic fclk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  zint_mc_if #(.CHANNELS(CH), .CTR_W(CW)) bus();
  zint_mc #(.CHANNELS(CH), .CTR_W(CW)) dut (.fclk(fclk), .rst(rst), .bus(bus));

  always #5 fclk = ~fclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  function automatic logic [7:0] exp_vec(input logic [7:0] vb, input int ch);
    logic [2:0] c;
    c = ch[2:0];
    return {vb[7:4], c, vb[0]};
  endfunction

  function automatic int lowest(input logic [CH-1:0] m);
    for (int i = 0; i < CH; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int eff_len(input int pl);
    return (pl == 0) ? 1 : pl;
  endfunction

  function automatic logic [CH-1:0] onehot(input int ch);
    return CH'(1) << ch;
  endfunction

  task automatic step();
    @(negedge fclk);
  endtask

  task automatic pulse_req(input logic [CH-1:0] m);
    bus.int_req = m;
    step();
    bus.int_req = '0;
  endtask

  task automatic do_ack();
    bus.iorq_n = 1'b0;
    bus.m1_n   = 1'b0;
    bus.zneg   = 1'b1;
    step();
    bus.zneg   = 1'b0;
  endtask

  task automatic release_bus();
    bus.iorq_n = 1'b1;
    bus.m1_n   = 1'b1;
    step();
  endtask

  task automatic wait_low(input string name, input int budget, output int gap);
    gap = 0;
    while (bus.int_n !== 1'b0 && gap < budget) begin
      step();
      gap++;
    end
    checks++;
    if (bus.int_n !== 1'b0) begin
      errors++;
      $display("FAIL %s: int_n=%b after %0d cycles, required 0", name, bus.int_n, gap);
    end
  endtask

  task automatic count_low(output int n);
    n = 0;
    while (bus.int_n === 1'b0 && n < 2000) begin
      n++;
      step();
    end
  endtask

  task automatic count_lows_over(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.int_n !== 1'b1) lows++;
    end
  endtask

  task automatic test_reset();
    int lows;
    rst = 1'b1;
    bus.int_req = '1;
    repeat (3) step();
    checks++;
    if ({bus.int_n, bus.int_vec, bus.int_vec_oe, bus.int_ack, bus.int_miss} !== {1'b1, 8'h00, 1'b0, 4'h0, 4'h0}) begin
      errors++;
      $display("FAIL reset_outputs: int_n=%b vec=%h oe=%b ack=%b miss=%b, required 1/00/0/0000/0000",
               bus.int_n, bus.int_vec, bus.int_vec_oe, bus.int_ack, bus.int_miss);
    end
    rst = 1'b0;
    bus.int_req = '0;
    count_lows_over(5, lows);
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL reset_ignores_req: int_n low %0d cycles, required 0", lows);
    end
  endtask

  task automatic test_timeout();
    int gap, n, lows;
    bus.pulse_len = 10'd256;
    pulse_req(4'b0001);
    wait_low("timeout_start", 10, gap);
    count_low(n);
    checks++;
    if (n != eff_len(256)) begin
      errors++;
      $display("FAIL timeout_len: int_n low %0d cycles, required %0d", n, eff_len(256));
    end
    checks++;
    if (bus.int_miss !== 4'b0001 || bus.int_ack !== 4'b0000) begin
      errors++;
      $display("FAIL timeout_miss: miss=%b ack=%b, required 0001/0000", bus.int_miss, bus.int_ack);
    end
    count_lows_over(5, lows);
    checks++;
    if (bus.int_miss !== 4'b0000 || lows != 0) begin
      errors++;
      $display("FAIL timeout_after: miss=%b lows=%0d, required 0000/0", bus.int_miss, lows);
    end
  endtask

  task automatic test_ack();
    int gap;
    bus.vec_base = 8'hF0;
    pulse_req(4'b0100);
    wait_low("ack_start", 10, gap);
    repeat (19) step();
    do_ack();
    checks++;
    if ({bus.int_n, bus.int_vec, bus.int_ack, bus.int_vec_oe} !== {1'b1, exp_vec(8'hF0, 2), onehot(2), 1'b1}) begin
      errors++;
      $display("FAIL ack_response: int_n=%b vec=%h ack=%b oe=%b, required 1/%h/%b/1",
               bus.int_n, bus.int_vec, bus.int_ack, bus.int_vec_oe, exp_vec(8'hF0, 2), onehot(2));
    end
    bus.m1_n = 1'b1;
    repeat (2) step();
    checks++;
    if (bus.int_vec_oe !== 1'b1 || bus.int_ack !== 4'b0000) begin
      errors++;
      $display("FAIL ack_hold: oe=%b ack=%b, required 1/0000", bus.int_vec_oe, bus.int_ack);
    end
    release_bus();
    checks++;
    if (bus.int_vec_oe !== 1'b0) begin
      errors++;
      $display("FAIL ack_release: oe=%b, required 0", bus.int_vec_oe);
    end
  endtask

  task automatic test_priority();
    logic [CH-1:0] pend;
    int gap, ch;
    pend = 4'b1010;
    pulse_req(pend);
    for (int k = 0; k < 2; k++) begin
      ch = lowest(pend);
      wait_low("prio_start", 10, gap);
      if (k == 1) begin
        checks++;
        if (gap < 1) begin
          errors++;
          $display("FAIL prio_gap: %0d high cycles between pulses, required >=1", gap);
        end
      end
      repeat (3) step();
      do_ack();
      checks++;
      if (bus.int_vec !== exp_vec(8'hF0, ch) || bus.int_ack !== onehot(ch)) begin
        errors++;
        $display("FAIL prio_order: vec=%h ack=%b, required %h/%b", bus.int_vec, bus.int_ack,
                 exp_vec(8'hF0, ch), onehot(ch));
      end
      pend &= ~onehot(ch);
      release_bus();
    end
  endtask

  task automatic test_ack_timeout_same();
    int gap, ch;
    ch = $urandom_range(0, CH - 1);
    bus.pulse_len = 10'd5;
    pulse_req(onehot(ch));
    wait_low("acktmo_start", 10, gap);
    repeat (eff_len(5) - 1) step();
    do_ack();
    checks++;
    if (bus.int_ack !== onehot(ch) || bus.int_miss !== 4'b0000 || bus.int_vec_oe !== 1'b1) begin
      errors++;
      $display("FAIL ack_beats_timeout: ack=%b miss=%b oe=%b, required %b/0000/1",
               bus.int_ack, bus.int_miss, bus.int_vec_oe, onehot(ch));
    end
    release_bus();
    step();
    checks++;
    if (bus.int_miss !== 4'b0000 || bus.int_n !== 1'b1) begin
      errors++;
      $display("FAIL ack_timeout_after: miss=%b int_n=%b, required 0000/1", bus.int_miss, bus.int_n);
    end
  endtask

  task automatic test_rereq();
    int gap;
    bus.pulse_len = 10'd256;
    pulse_req(4'b0001);
    wait_low("rereq_first", 10, gap);
    repeat (3) step();
    bus.int_req = 4'b0001;
    do_ack();
    bus.int_req = '0;
    checks++;
    if (bus.int_ack !== 4'b0001) begin
      errors++;
      $display("FAIL rereq_ack: ack=%b, required 0001", bus.int_ack);
    end
    step();
    release_bus();
    wait_low("rereq_second", 10, gap);
    do_ack();
    checks++;
    if (bus.int_ack !== 4'b0001) begin
      errors++;
      $display("FAIL rereq_second_ack: ack=%b, required 0001", bus.int_ack);
    end
    release_bus();
  endtask

  task automatic test_disable();
    int gap, lows;
    pulse_req(4'b0100);
    wait_low("dis_start", 10, gap);
    repeat (3) step();
    bus.int_en = 4'b1011;
    step();
    checks++;
    if (bus.int_n !== 1'b1 || bus.int_miss !== 4'b0000) begin
      errors++;
      $display("FAIL disable_release: int_n=%b miss=%b, required 1/0000", bus.int_n, bus.int_miss);
    end
    pulse_req(4'b0100);
    bus.int_en = 4'b1111;
    count_lows_over(5, lows);
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL disable_no_latch: int_n low %0d cycles, required 0", lows);
    end
  endtask

  task automatic test_reset_mid();
    int gap, n, lows;
    pulse_req(4'b0010);
    wait_low("rst_assert_start", 10, gap);
    repeat (4) step();
    rst = 1'b1;
    step();
    checks++;
    if (bus.int_n !== 1'b1 || bus.int_ack !== 4'b0000 || bus.int_miss !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_assert: int_n=%b ack=%b miss=%b, required 1/0000/0000",
               bus.int_n, bus.int_ack, bus.int_miss);
    end
    rst = 1'b0;
    count_lows_over(5, lows);
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL rst_clears_pend: int_n low %0d cycles, required 0", lows);
    end
    pulse_req(4'b0010);
    wait_low("rst_ackwait_start", 10, gap);
    do_ack();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (bus.int_vec_oe !== 1'b0 || bus.int_ack !== 4'b0000) begin
      errors++;
      $display("FAIL rst_mid_ackwait: oe=%b ack=%b, required 0/0000", bus.int_vec_oe, bus.int_ack);
    end
    rst = 1'b0;
    release_bus();
    bus.pulse_len = '0;
    pulse_req(4'b1000);
    wait_low("plen0_start", 10, gap);
    count_low(n);
    checks++;
    if (n != eff_len(0) || bus.int_miss !== 4'b1000) begin
      errors++;
      $display("FAIL plen_zero: low=%0d miss=%b, required %0d/1000", n, bus.int_miss, eff_len(0));
    end
  endtask

  task automatic test_plen_change();
    int gap, n;
    bus.pulse_len = 10'd200;
    pulse_req(4'b0010);
    wait_low("plen_chg_start", 10, gap);
    repeat (5) step();
    bus.pulse_len = 10'd12;
    count_low(n);
    checks++;
    if (n + 5 != 12 || bus.int_miss !== 4'b0010) begin
      errors++;
      $display("FAIL plen_change: low=%0d miss=%b, required 12/0010", n + 5, bus.int_miss);
    end
  endtask

  task automatic test_random();
    logic [CH-1:0] pend;
    logic [7:0]    vb;
    int pl, ch, gap, n, k;
    for (int it = 0; it < 30; it++) begin
      vb = 8'($urandom);
      pl = $urandom_range(0, 24);
      bus.vec_base  = vb;
      bus.pulse_len = CW'(pl);
      pend = CH'($urandom_range(1, 15));
      pulse_req(pend);
      while (pend != '0) begin
        ch = lowest(pend);
        wait_low("rand_start", 10, gap);
        if ($urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, eff_len(pl) - 1);
          repeat (k) step();
          do_ack();
          checks++;
          if ({bus.int_n, bus.int_ack, bus.int_miss, bus.int_vec} !== {1'b1, onehot(ch), 4'b0000, exp_vec(vb, ch)}) begin
            errors++;
            $display("FAIL rand_ack it=%0d: int_n=%b ack=%b miss=%b vec=%h, required 1/%b/0000/%h",
                     it, bus.int_n, bus.int_ack, bus.int_miss, bus.int_vec, onehot(ch), exp_vec(vb, ch));
          end
          repeat ($urandom_range(0, 2)) step();
          release_bus();
        end else begin
          count_low(n);
          checks++;
          if (n != eff_len(pl) || bus.int_miss !== onehot(ch) || bus.int_ack !== 4'b0000) begin
            errors++;
            $display("FAIL rand_timeout it=%0d: low=%0d miss=%b ack=%b, required %0d/%b/0000",
                     it, n, bus.int_miss, bus.int_ack, eff_len(pl), onehot(ch));
          end
        end
        pend &= ~onehot(ch);
      end
      step();
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.zpos      = 1'b0;
    bus.zneg      = 1'b0;
    bus.int_req   = '0;
    bus.int_en    = '1;
    bus.pulse_len = 10'd256;
    bus.vec_base  = 8'hF0;
    bus.iorq_n    = 1'b1;
    bus.m1_n      = 1'b1;
    step();
    test_reset();
    test_timeout();
    test_ack();
    test_priority();
    test_ack_timeout_same();
    test_rereq();
    test_disable();
    test_reset_mid();
    test_plen_change();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
